// File: rtl/sr_cmd_conditioner.sv
// Debounced, mutually exclusive S/R pulse generator with holdoff spacing for an SR flip-flop.
// Define SR_CMD_COUNT_EN to add the set_count/reset_count issue counters.
module sr_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 3,
  parameter bit PRIO_SET        = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_btn,
  input  logic       reset_btn,
  output logic       S,
  output logic       R,
  output logic       busy,
  output logic       conflict
`ifdef SR_CMD_COUNT_EN
  ,
  output logic [7:0] set_count,
  output logic [7:0] reset_count
`endif
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HO_LAST = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // Channel index 0 is set, index 1 is reset.
  logic [1:0] raw;
  logic [1:0] req;
  assign raw = {reset_btn, set_btn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic [DW-1:0] cnt_q;
    logic          accept;

    assign accept  = (sync2_q != stable_q) && (cnt_q == DB_LAST);
    // Request fires in the same cycle the stable level is about to rise.
    assign req[gi] = accept && sync2_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q <= raw[gi];
        sync2_q <= sync1_q;
        if (sync2_q == stable_q) begin
          cnt_q <= '0;
        end else if (accept) begin
          stable_q <= sync2_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  state_t        state_q;
  logic [HW-1:0] hcnt_q;
  logic [1:0]    pend_q;
  logic          s_q, r_q, busy_q, conflict_q;

  logic [1:0] pend_m;
  logic [1:0] cand;
  logic [1:0] issue;
  logic       hold_done;
  logic       fire;

  assign pend_m    = pend_q | req;
  assign hold_done = (hcnt_q == HO_LAST);
  assign cand      = (state_q == IDLE) ? req : pend_m;
  assign fire      = (state_q == IDLE) ? (req != 2'b00) : (hold_done && (pend_m != 2'b00));

  always_comb begin
    issue = cand;
    if (cand == 2'b11) issue = PRIO_SET ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hcnt_q     <= '0;
      pend_q     <= 2'b00;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q <= 1'b0;
      r_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fire) begin
            s_q     <= issue[0];
            r_q     <= issue[1];
            pend_q  <= cand & ~issue;
            hcnt_q  <= '0;
            state_q <= HOLD;
            busy_q  <= 1'b1;
            if (cand == 2'b11) conflict_q <= 1'b1;
          end
        end
        HOLD: begin
          if (!hold_done) begin
            hcnt_q <= hcnt_q + 1'b1;
            pend_q <= pend_m;
          end else if (!fire) begin
            pend_q  <= 2'b00;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            s_q    <= issue[0];
            r_q    <= issue[1];
            pend_q <= cand & ~issue;
            hcnt_q <= '0;
            if (cand == 2'b11) conflict_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

`ifdef SR_CMD_COUNT_EN
  logic [7:0] set_count_q, reset_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_count_q   <= 8'd0;
      reset_count_q <= 8'd0;
    end else if (fire) begin
      if (issue[0]) set_count_q <= set_count_q + 8'd1;
      if (issue[1]) reset_count_q <= reset_count_q + 8'd1;
    end
  end

  assign set_count   = set_count_q;
  assign reset_count = reset_count_q;
`endif

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed bench for sr_cmd_conditioner at DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=3, PRIO_SET=0.
// Edge 0 is the first rising edge that samples a newly raised button.
module tb_sr_cmd_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic set_btn = 1'b0;
  logic reset_btn = 1'b0;
  logic S, R, busy, conflict;
`ifdef SR_CMD_COUNT_EN
  logic [7:0] set_count, reset_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sr_cmd_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (3),
    .PRIO_SET       (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .set_btn  (set_btn),
    .reset_btn(reset_btn),
    .S        (S),
    .R        (R),
    .busy     (busy),
    .conflict (conflict)
`ifdef SR_CMD_COUNT_EN
    ,
    .set_count  (set_count),
    .reset_count(reset_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    set_btn = 1'b0;
    reset_btn = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_btn = 1'b1;
    reset_btn = 1'b1;
    repeat (8) tick();
    n_cmp++; if (S !== 1'b0) begin n_bad++; $display("FAIL reset_S got %b want 0", S); end
    n_cmp++; if (R !== 1'b0) begin n_bad++; $display("FAIL reset_R got %b want 0", R); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (conflict !== 1'b0) begin n_bad++; $display("FAIL reset_conflict got %b want 0", conflict); end
    $display("test_reset: outputs held low with buttons asserted during reset");
  endtask

  task automatic test_latency();
    apply_reset();
    set_btn = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_cmp++; if (S !== (e == 5)) begin n_bad++; $display("FAIL latency_S edge %0d got %b want %b", e, S, (e == 5)); end
      n_cmp++; if (R !== 1'b0) begin n_bad++; $display("FAIL latency_R edge %0d got %b want 0", e, R); end
      n_cmp++; if (busy !== (e >= 5 && e <= 7)) begin n_bad++; $display("FAIL latency_busy edge %0d got %b want %b", e, busy, (e >= 5 && e <= 7)); end
    end
    set_btn = 1'b0;
    repeat (10) tick();
    $display("test_latency: clean set press checked over 10 edges");
  endtask

  task automatic test_bounce();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      set_btn = (i % 2 == 0);
      repeat (2) begin
        tick();
        n_cmp++; if (S !== 1'b0 || R !== 1'b0) begin n_bad++; $display("FAIL bounce_quiet seg %0d got S=%b R=%b want 0/0", i, S, R); end
      end
    end
    set_btn = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_cmp++; if (S !== (e == 5)) begin n_bad++; $display("FAIL bounce_settle_S edge %0d got %b want %b", e, S, (e == 5)); end
    end
    set_btn = 1'b0;
    repeat (10) tick();
    $display("test_bounce: 20-cycle bounce then settle checked");
  endtask

  task automatic test_contention();
    apply_reset();
    set_btn = 1'b1;
    reset_btn = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      n_cmp++; if (R !== (e == 5)) begin n_bad++; $display("FAIL contend_R edge %0d got %b want %b", e, R, (e == 5)); end
      n_cmp++; if (S !== (e == 8)) begin n_bad++; $display("FAIL contend_S edge %0d got %b want %b", e, S, (e == 8)); end
      n_cmp++; if (conflict !== (e >= 5)) begin n_bad++; $display("FAIL contend_conflict edge %0d got %b want %b", e, conflict, (e >= 5)); end
      n_cmp++; if (busy !== (e >= 5 && e <= 10)) begin n_bad++; $display("FAIL contend_busy edge %0d got %b want %b", e, busy, (e >= 5 && e <= 10)); end
    end
    set_btn = 1'b0;
    reset_btn = 1'b0;
    repeat (10) tick();
    n_cmp++; if (conflict !== 1'b1) begin n_bad++; $display("FAIL contend_sticky got %b want 1", conflict); end
    $display("test_contention: simultaneous presses, R first then S");
  endtask

  task automatic test_holdoff();
    apply_reset();
    reset_btn = 1'b1;
    tick();
    set_btn = 1'b1;
    for (int e = 1; e < 13; e++) begin
      tick();
      n_cmp++; if (R !== (e == 5)) begin n_bad++; $display("FAIL holdoff_R edge %0d got %b want %b", e, R, (e == 5)); end
      n_cmp++; if (S !== (e == 8)) begin n_bad++; $display("FAIL holdoff_S edge %0d got %b want %b", e, S, (e == 8)); end
      n_cmp++; if (conflict !== 1'b0) begin n_bad++; $display("FAIL holdoff_conflict edge %0d got %b want 0", e, conflict); end
      n_cmp++; if (busy !== (e >= 5 && e <= 10)) begin n_bad++; $display("FAIL holdoff_busy edge %0d got %b want %b", e, busy, (e >= 5 && e <= 10)); end
    end
    set_btn = 1'b0;
    reset_btn = 1'b0;
    repeat (10) tick();
    $display("test_holdoff: set request during holdoff deferred to k+3");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_btn = 1'b1;
    reset_btn = 1'b1;
    repeat (6) tick();
    n_cmp++; if (R !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_R got %b want 1", R); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (R !== 1'b0) begin n_bad++; $display("FAIL midrst_R got %b want 0", R); end
    n_cmp++; if (S !== 1'b0) begin n_bad++; $display("FAIL midrst_S got %b want 0", S); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_cmp++; if (conflict !== 1'b0) begin n_bad++; $display("FAIL midrst_conflict got %b want 0", conflict); end
    reset_btn = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    for (int e = 0; e < 13; e++) begin
      tick();
      n_cmp++; if (S !== (e == 5)) begin n_bad++; $display("FAIL midrst_after_S edge %0d got %b want %b", e, S, (e == 5)); end
      n_cmp++; if (R !== 1'b0) begin n_bad++; $display("FAIL midrst_after_R edge %0d got %b want 0", e, R); end
      n_cmp++; if (conflict !== 1'b0) begin n_bad++; $display("FAIL midrst_after_conflict edge %0d got %b want 0", e, conflict); end
    end
    set_btn = 1'b0;
    repeat (10) tick();
    $display("test_reset_mid: async reset discards pending S, held button re-debounced");
  endtask

`ifdef SR_CMD_COUNT_EN
  task automatic test_counts();
    apply_reset();
    for (int p = 0; p < 257; p++) begin
      set_btn = 1'b1;
      repeat (8) tick();
      set_btn = 1'b0;
      repeat (8) tick();
    end
    n_cmp++; if (set_count !== 8'd1) begin n_bad++; $display("FAIL count_set got %0d want 1", set_count); end
    n_cmp++; if (reset_count !== 8'd0) begin n_bad++; $display("FAIL count_reset got %0d want 0", reset_count); end
    $display("test_counts: 257 set presses, counter wrap checked");
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_contention();
    test_holdoff();
    test_reset_mid();
`ifdef SR_CMD_COUNT_EN
    test_counts();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sr_cmd_conditioner.md
Name: sr_cmd_conditioner

Overview:
- Upstream command stage for the SR flip-flop.
- Takes two raw, asynchronous, bouncy inputs (set button, reset button) and synchronizes and debounces each one.
- Emits clean single-cycle S and R pulses that drive the flip-flop's S/R inputs directly.
- Guarantees S and R are never high in the same cycle, so the illegal 11 case never occurs, and enforces a minimum spacing between commands.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized level must hold before it is accepted; minimum 1.
- HOLDOFF_CYCLES, 3: minimum cycles between issued pulses; minimum 1.
- PRIO_SET, 0: when both requests contend in one cycle, 1 means S wins and 0 means R wins.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- set_btn  input  1  raw asynchronous set request.
- reset_btn  input  1  raw asynchronous reset request.
- S  output  1  one-cycle set pulse to the flip-flop.
- R  output  1  one-cycle reset pulse to the flip-flop.
- busy  output  1  high while in HOLD.
- conflict  output  1  sticky flag: both requests contended in the same cycle.

Behaviour:
- Reset (rst=0, asynchronous): the following are all cleared to 0:
  - sync flops, stable levels, debounce counters, holdoff counter, pending flags;
  - FSM state to IDLE;
  - outputs S, R, busy, conflict.
- Reset mid-operation: pending or in-flight commands are discarded, and no pulse is emitted during reset.
- Button held through reset release: the stable level restarts at 0, so the button yields one pulse after the full debounce latency.
- Synchronizer: two flops per channel, giving sync2.
- Debounce, per channel, counter width clog2(DEBOUNCE_CYCLES), minimum 1 bit:
  - sync2==stable: counter cleared.
  - sync2!=stable and counter==DEBOUNCE_CYCLES-1: stable<=sync2, counter<=0.
  - Otherwise: counter+1.
  - Any bounce back to the stable value restarts the count.
- Request generation: a request is raised only in the cycle stable goes 0->1. Falling edges generate nothing.
- Latency: with the first clock edge sampling raw high counted as edge 0, the request is raised at edge DEBOUNCE_CYCLES+1. If the FSM is IDLE, the pulse is visible in the cycle following that edge.
- FSM, two states:
  - IDLE: no request → stay. One request → pulse that output, hcnt<=0, go to HOLD. Both requests → pulse the winner (per PRIO_SET), set the loser's pending flag, set conflict, go to HOLD.
  - HOLD: busy=1; hcnt increments each cycle. New requests set pending flags; a duplicate on an already-pending channel merges (no count). When hcnt==HOLDOFF_CYCLES-1, requests arriving that cycle are merged into pending, then:
    - pending empty → go to IDLE;
    - one pending → issue it, clear its flag, hcnt<=0, stay in HOLD;
    - both pending → issue the winner, keep the loser pending, set conflict, hcnt<=0, stay in HOLD.
- S/R are registered outputs, high exactly one cycle per issue, never both high.
- Pulse spacing: a pulse at edge k allows the next pulse no earlier than edge k+HOLDOFF_CYCLES.
- conflict stays set until reset.

Optional Feature:
- SR_CMD_COUNT_EN defined:
  - Adds output ports set_count[7:0] and reset_count[7:0].
  - Each increments by 1 in the cycle S (resp. R) is issued; wraps 255→0; reset value 0.
- Undefined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Debounce latency: DEBOUNCE_CYCLES=4, HOLDOFF=3; set_btn rises clean and held → single S pulse visible after edge 5 (edge 0 = first high sample); R stays 0; busy=1 for 3 cycles.
- Bounce rejection: set_btn toggles every 2 cycles for 20 cycles, then settles high → no pulse during bounce; exactly one S pulse, 6 edges after settling is first sampled.
- Simultaneous contention, PRIO_SET=0: both buttons rise in the same cycle → R pulse at edge 5, S pulse at edge 8, conflict=1 from edge 5 and held.
- Holdoff pending: R issued at edge k; set request arrives at k+1 → S pulse at edge k+3, never earlier; a second set request at k+2 merges and produces no extra pulse.
- Reset mid-holdoff: pending S exists, rst=0 asynchronously between edges → S, R, busy, conflict drop to 0 immediately; after release, no stale pulse; a button still held yields one pulse 6 edges later.
- With SR_CMD_COUNT_EN: 257 isolated set presses → set_count=1 (wrapped); reset_count=0.
